// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// The master side drives requests, weights and beats; the slave side returns the grant.
interface weighted_rr_arbiter_if #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned W_WEIGHT = 4
);
  localparam int unsigned W_IDX = $clog2(N_REQ);

  logic [N_REQ-1:0]          req;
  logic [N_REQ*W_WEIGHT-1:0] weight;
  logic                      beat;
  logic [N_REQ-1:0]          grant;
  logic [W_IDX-1:0]          grant_idx;
  logic                      grant_valid;
  logic [W_WEIGHT-1:0]       credit;

  modport master (
    output req,
    output weight,
    output beat,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  credit
  );

  modport slave (
    input  req,
    input  weight,
    input  beat,
    output grant,
    output grant_idx,
    output grant_valid,
    output credit
  );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: registered, zero-bubble grants that last up to
// the winner's weight in beats, with a rotating search valid for any N_REQ.
module weighted_rr_arbiter #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned W_WEIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  weighted_rr_arbiter_if.slave bus
);
  localparam int unsigned W_IDX = $clog2(N_REQ);
  localparam logic [W_IDX-1:0] LastIdx = W_IDX'(N_REQ - 1);
  localparam logic [W_IDX:0]   NReqW   = (W_IDX + 1)'(N_REQ);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [W_IDX-1:0]    r_grant_idx;
  logic [W_IDX-1:0]    r_last_idx;
  logic [W_WEIGHT-1:0] r_credit;

  logic                w_cur_req;
  logic                w_end;
  logic [W_IDX-1:0]    w_search_last;
  logic [W_IDX-1:0]    w_start;
  logic [2*N_REQ-1:0]  w_dbl;
  logic [N_REQ-1:0]    w_rot;
  logic                w_found;
  logic [W_IDX-1:0]    w_offset;
  logic [W_IDX:0]      w_sum;
  logic [W_IDX-1:0]    w_win_idx;
  logic [N_REQ-1:0]    w_win_onehot;
  logic [W_WEIGHT-1:0] w_win_credit;

  always_comb begin
    w_cur_req = bus.req[r_grant_idx];
    w_end     = (r_state == StGrant) &&
                (!w_cur_req || (bus.beat && (r_credit == W_WEIGHT'(1))));

    // On a grant end the search pointer is the ending index, not the stale last_idx.
    w_search_last = w_end ? r_grant_idx : r_last_idx;
    w_start       = (w_search_last == LastIdx) ? '0 : w_search_last + W_IDX'(1);

    w_dbl   = {bus.req, bus.req};
    w_rot   = w_dbl[w_start +: N_REQ];
    w_found = |w_rot;

    w_offset = '0;
    for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
      if (w_rot[j]) w_offset = W_IDX'(j);
    end

    w_sum     = {1'b0, w_start} + {1'b0, w_offset};
    w_win_idx = (w_sum >= NReqW) ? W_IDX'(w_sum - NReqW) : w_sum[W_IDX-1:0];

    w_win_onehot = N_REQ'(1) << w_win_idx;

    w_win_credit = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_win_idx == W_IDX'(i)) w_win_credit = bus.weight[i*W_WEIGHT +: W_WEIGHT];
    end
    if (w_win_credit == '0) w_win_credit = W_WEIGHT'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_credit    <= '0;
      r_last_idx  <= LastIdx;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state     <= StGrant;
            r_grant_idx <= w_win_idx;
            r_grant     <= w_win_onehot;
            r_credit    <= w_win_credit;
          end
        end
        StGrant: begin
          if (w_end) begin
            r_last_idx <= r_grant_idx;
            if (w_found) begin
              r_grant_idx <= w_win_idx;
              r_grant     <= w_win_onehot;
              r_credit    <= w_win_credit;
            end else begin
              r_state  <= StIdle;
              r_grant  <= '0;
              r_credit <= '0;
            end
          end else if (bus.beat) begin
            r_credit <= r_credit - W_WEIGHT'(1);
          end
        end
        default: begin
          r_state  <= StIdle;
          r_grant  <= '0;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.grant_valid = (r_state == StGrant);
  assign bus.credit      = r_credit;
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench: an 8-requester instance checked against a behavioural model,
// plus a 5-requester instance checked against a fixed wrap sequence.
module tb_weighted_rr_arbiter;
  logic clk;
  logic rst_n8;
  logic rst_n5;

  weighted_rr_arbiter_if #(.N_REQ(8), .W_WEIGHT(4)) if8 ();
  weighted_rr_arbiter_if #(.N_REQ(5), .W_WEIGHT(4)) if5 ();

  weighted_rr_arbiter #(.N_REQ(8), .W_WEIGHT(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .bus   (if8)
  );

  weighted_rr_arbiter #(.N_REQ(5), .W_WEIGHT(4)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n5),
    .bus   (if5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic [3:0] credit;
    logic [7:0] grant;
  } exp8_t;

  exp8_t q8[$];
  int    q5_idx[$];
  int    q5_cr[$];
  int    n_vec = 0;
  int    n_err = 0;

  int m_valid;
  int m_idx;
  int m_credit;
  int m_last;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: linear circular scan from last+1, independent of the rotate/encode datapath.
  task automatic model_step(input logic rst, input logic [7:0] req, input logic [31:0] wt,
                            input logic beat);
    bit found;
    int win;
    if (!rst) begin
      m_valid = 0; m_idx = 0; m_credit = 0; m_last = 7;
      return;
    end
    if (m_valid != 0 && req[m_idx] && !(beat && m_credit == 1)) begin
      if (beat) m_credit--;
      return;
    end
    if (m_valid != 0) m_last = m_idx;
    found = 0;
    win   = 0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && req[(m_last + k) % 8]) begin
        found = 1;
        win   = (m_last + k) % 8;
      end
    end
    if (found) begin
      m_valid  = 1;
      m_idx    = win;
      m_credit = (wt[win*4 +: 4] == 4'd0) ? 1 : int'(wt[win*4 +: 4]);
    end else begin
      m_valid  = 0;
      m_credit = 0;
    end
  endtask

  task automatic step8(input logic rst, input logic [7:0] req, input logic [31:0] wt,
                       input logic beat);
    exp8_t e;
    exp8_t g;
    rst_n8     = rst;
    if8.req    = req;
    if8.weight = wt;
    if8.beat   = beat;
    model_step(rst, req, wt, beat);
    e.valid  = (m_valid != 0);
    e.idx    = 3'(m_idx);
    e.credit = 4'(m_credit);
    e.grant  = (m_valid != 0) ? (8'd1 << m_idx) : 8'd0;
    q8.push_back(e);
    @(posedge clk);
    #1;
    g = q8.pop_front();
    check_eq("valid8", int'(if8.grant_valid), int'(g.valid));
    check_eq("grant8", int'(if8.grant), int'(g.grant));
    check_eq("credit8", int'(if8.credit), int'(g.credit));
    if (g.valid) check_eq("idx8", int'(if8.grant_idx), int'(g.idx));
  endtask

  task automatic step5(input logic rst, input logic [4:0] req, input logic beat,
                       input int exp_idx, input int exp_cr);
    int ei;
    int ec;
    rst_n5     = rst;
    if5.req    = req;
    if5.weight = 20'h22222;
    if5.beat   = beat;
    q5_idx.push_back(exp_idx);
    q5_cr.push_back(exp_cr);
    @(posedge clk);
    #1;
    ei = q5_idx.pop_front();
    ec = q5_cr.pop_front();
    check_eq("credit5", int'(if5.credit), ec);
    if (ec != 0) check_eq("idx5", int'(if5.grant_idx), ei);
    else         check_eq("valid5", int'(if5.grant_valid), 0);
  endtask

  initial begin
    int          cr1[4];
    int          idx5[6];
    int          cr5[6];
    logic [31:0] wt;
    cr1  = '{3, 2, 1, 3};
    idx5 = '{0, 0, 4, 4, 0, 0};
    cr5  = '{2, 1, 2, 1, 2, 1};

    rst_n8 = 1'b0; rst_n5 = 1'b0;
    if8.req = '0; if8.weight = '0; if8.beat = 1'b0;
    if5.req = '0; if5.weight = '0; if5.beat = 1'b0;
    #3;

    step8(1'b0, 8'h00, 32'h0, 1'b0);
    step8(1'b0, 8'h00, 32'h0, 1'b0);
    check_eq("rst_grant", int'(if8.grant), 0);

    // Single requester, weight 3, beat every cycle: 3,2,1 then fresh re-grant.
    wt = 32'h0000_0003;
    for (int i = 0; i < 4; i++) begin
      step8(1'b1, 8'h01, wt, 1'b1);
      check_eq("t1_idx", int'(if8.grant_idx), 0);
      check_eq("t1_credit", int'(if8.credit), cr1[i]);
    end

    step8(1'b0, 8'h00, 32'h0, 1'b0);
    wt = 32'h1111_1111;
    for (int i = 0; i < 10; i++) begin
      step8(1'b1, 8'hFF, wt, 1'b1);
      check_eq("t2_seq", int'(if8.grant_idx), i % 8);
    end

    // Withdrawal of the grantee hands over on the same edge.
    step8(1'b0, 8'h00, 32'h0, 1'b0);
    wt = 32'h0060_0400;
    for (int i = 0; i < 3; i++) step8(1'b1, 8'h24, wt, 1'b0);
    check_eq("t3_hold_idx", int'(if8.grant_idx), 2);
    check_eq("t3_hold_credit", int'(if8.credit), 4);
    step8(1'b1, 8'h20, wt, 1'b0);
    check_eq("t3_wd_idx", int'(if8.grant_idx), 5);
    check_eq("t3_wd_credit", int'(if8.credit), 6);

    step8(1'b0, 8'h00, 32'h0, 1'b0);
    wt = 32'h1111_0111;
    for (int i = 0; i < 3; i++) begin
      step8(1'b1, 8'h08, wt, 1'b1);
      check_eq("t4_zero_credit", int'(if8.credit), 1);
    end
    for (int i = 0; i < 4; i++) step8(1'b1, 8'h08, wt, 1'b0);
    check_eq("t4_hold_valid", int'(if8.grant_valid), 1);
    check_eq("t4_hold_credit", int'(if8.credit), 1);

    step8(1'b0, 8'h00, 32'h0, 1'b0);
    wt = 32'h1111_1111;
    step8(1'b1, 8'hFF, wt, 1'b1);
    step8(1'b1, 8'hFF, wt, 1'b1);
    check_eq("t5_pre_idx", int'(if8.grant_idx), 1);
    step8(1'b0, 8'hFF, wt, 1'b1);
    check_eq("t5_rst_grant", int'(if8.grant), 0);
    check_eq("t5_rst_credit", int'(if8.credit), 0);
    step8(1'b1, 8'hFF, wt, 1'b0);
    check_eq("t5_first_idx", int'(if8.grant_idx), 0);

    step8(1'b0, 8'h00, 32'h0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      step8(($urandom_range(0, 49) != 0), r, $urandom, 1'($urandom));
    end

    // Five requesters: wrap across a non-power-of-two width.
    step5(1'b0, 5'b00000, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) step5(1'b1, 5'b10001, 1'b1, idx5[i], cr5[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
